// File: rtl/fifo_width_converter.sv
// fifo_width_converter: FWFT FIFO that packs narrow writes into wide storage
// words (UP), unpacks wide writes into narrow reads (DOWN) or passes words
// straight through (EQUAL). Mode is chosen at elaboration from the widths.
// Optional macro FIFO_WIDTH_CONV_FLUSH_EN: in UP mode, wr_last closes the
// partially packed word early (unfilled upper lanes are zero).
module fifo_width_converter #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int ADDR_WIDTH     = 8,
    parameter int FULL_SLACK     = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_ena,
    input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
    input  logic                      wr_last,
    output logic                      wr_full,
    input  logic                      rd_ena,
    output logic [DATA_OUT_WIDTH-1:0] rd_dat,
    output logic                      rd_empty,
    output logic [ADDR_WIDTH:0]       rd_dat_cnt
);

    localparam int SW    = (DATA_OUT_WIDTH > DATA_IN_WIDTH) ? DATA_OUT_WIDTH : DATA_IN_WIDTH;
    localparam int RU    = (DATA_OUT_WIDTH > DATA_IN_WIDTH) ? DATA_OUT_WIDTH / DATA_IN_WIDTH : 1;
    localparam int RD    = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH / DATA_OUT_WIDTH : 1;
    localparam int LWU   = (RU > 1) ? $clog2(RU) : 1;
    localparam int LWD   = (RD > 1) ? $clog2(RD) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (FULL_SLACK == 0) ?
        (ADDR_WIDTH+1)'(DEPTH) : (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);

    logic [SW-1:0]         r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;

    logic          w_rd_fire;
    logic          w_pop;
    logic          w_push;
    logic          w_wr_acc;
    logic [SW-1:0] w_wdat;
    logic [SW-1:0] w_head;
    logic          w_unused_last;

    // wr_last only matters in UP mode with the flush macro
    assign w_unused_last = wr_last;

    assign rd_dat_cnt = r_cnt;
    assign rd_empty   = (r_cnt == '0);
    assign wr_full    = (r_cnt >= FULL_LVL);
    assign w_rd_fire  = rd_ena && !rd_empty;
    assign w_head     = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a write at full still lands
    // and the occupancy stays put when a word is both pushed and popped.
    assign w_wr_acc   = wr_ena && (!wr_full || w_pop);

    generate
        if (RU > 1) begin : g_up
            logic [LWU-1:0] r_wr_lane;
            logic [SW-1:0]  r_pack;
            logic [SW-1:0]  w_pack;
            logic           w_flush;

            // merge the incoming word into its lane of the packing register
            always_comb begin
                w_pack = r_pack;
                w_pack[r_wr_lane*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
            end

`ifdef FIFO_WIDTH_CONV_FLUSH_EN
            assign w_flush = wr_last;
`else
            assign w_flush = 1'b0;
`endif

            assign w_push = w_wr_acc && ((r_wr_lane == LWU'(RU - 1)) || w_flush);
            assign w_wdat = w_pack;

            // lane counter and partial word; cleared after each completed word
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wr_lane <= '0;
                    r_pack    <= '0;
                end else if (w_wr_acc) begin
                    if (w_push) begin
                        r_wr_lane <= '0;
                        r_pack    <= '0;
                    end else begin
                        r_wr_lane <= r_wr_lane + LWU'(1);
                        r_pack    <= w_pack;
                    end
                end
            end
        end else begin : g_flat
            assign w_push = w_wr_acc;
            assign w_wdat = wr_dat;
        end

        if (RD > 1) begin : g_down
            logic [LWD-1:0] r_rd_lane;

            assign w_pop = w_rd_fire && (r_rd_lane == LWD'(RD - 1));

            // present the current lane of the head word, zero when empty
            always_comb begin
                rd_dat = '0;
                if (!rd_empty) begin
                    rd_dat = w_head[r_rd_lane*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
                end
            end

            // read lane advances per accepted read, wraps when the head pops
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rd_lane <= '0;
                end else if (w_rd_fire) begin
                    r_rd_lane <= w_pop ? '0 : r_rd_lane + LWD'(1);
                end
            end
        end else begin : g_whole
            assign w_pop = w_rd_fire;

            // head word straight out, zero when empty
            always_comb begin
                rd_dat = '0;
                if (!rd_empty) begin
                    rd_dat = w_head;
                end
            end
        end
    endgenerate

    // storage array write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdat;
        end
    end

    // pointers wrap naturally; occupancy tracks push/pop of whole words
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule
